regfile_dump_reader: RTL and testbench
======================================

# regfile_dump_reader

Debug read-out engine for the 32×32 integer register file. On a start request it walks a range of register indices through a dedicated combinational read port of the register file. It streams each value out over a valid/ready channel toward the debug/trace interface. It is the reader counterpart to the core's writeback path and never writes the register file.

## Interface
- RF_DEPTH, 32, number of architectural registers (index width = 5)
- DATA_W, 32, register width
- FORCE_X0_ZERO, 1, when 1 index 0 is always reported as 32'h0 regardless of read data
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a dump; sampled only in IDLE
- abort  in  1  synchronous cancel; wins over every other input
- first_idx  in  5  first register index, latched on accepted start
- last_idx  in  5  final register index, latched on accepted start
- rf_raddr  out  5  read address to the register file debug port
- rf_rdata  in  32  combinational read data for rf_raddr
- dout_valid  out  1  output word valid
- dout_ready  in  1  consumer accepts the word
- dout_data  out  32  register value
- dout_idx  out  5  index of dout_data
- dout_last  out  1  marks the final word of the dump
- busy  out  1  high in READ and SEND
- done  out  1  one-cycle pulse after the last handshake, or after abort

## Operation
- FSM states:
  - IDLE: start=1 latches first_idx into idx and last_idx into end, then goes to READ. start in any other state is ignored.
  - READ: rf_raddr=idx. At the clock edge, dout_data<=rf_rdata (or 0 if idx==0 and FORCE_X0_ZERO), dout_idx<=idx, dout_last<=(idx==end), dout_valid<=1, then go to SEND.
  - SEND: hold all dout_* stable until dout_ready. When dout_valid&&dout_ready:
    - if dout_last, dout_valid<=0 and go to DONE.
    - otherwise dout_valid<=0, idx<=idx+1 (mod 32), and go to READ.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Index arithmetic is 5-bit and wraps 31→0. The word count is ((last_idx−first_idx) mod 32)+1, so it ranges from 1 to 32.
  - first==last gives 1 word.
  - first=0, last=31 gives a full dump.
  - first=5, last=4 gives 32 words: 5..31 then 0..4.
- Captured value is the register content as seen combinationally in the READ cycle. A writeback to the same index in that cycle is not bypassed: the old value is captured.
- abort in any non-IDLE state forces dout_valid=0 and sends the FSM to DONE. done pulses and no further words are sent. abort in IDLE is ignored.
- rf_raddr is 0 outside READ.

## Timing
- Reset values: rf_raddr=0, dout_valid=0, dout_data=0, dout_idx=0, dout_last=0, busy=0, done=0, state IDLE.
- Reset mid-dump ends the dump immediately. No done pulse is produced.
- Start accepted at the edge ending cycle T. READ occupies T+1 and dout_valid is high from T+2.
- With dout_ready held high, throughput is 1 word per 2 cycles. An N-word dump takes 2N cycles from start to last handshake, and done is high in the next cycle.
- All outputs are registered except rf_raddr and busy, which decode the state directly.
- dout_valid never drops without a handshake, except on abort or reset.

## Structure
- Shared package rf_pkg holds:
  - RF_ADDR_W=5, RF_DATA_W=32, RF_DEPTH=32
  - the dump FSM state type: IDLE, READ, SEND, DONE
- The register file keeps its existing ports and gains one extra combinational read port for rf_raddr/rf_rdata.
- Single module; no sub-module.

## Test plan
- Preload x1..x31 = 32'h1000_0000+i, start with first=1, last=3, dout_ready=1 → words (1,32'h1000_0001), (2,32'h1000_0002), (3,32'h1000_0003,last=1), then done pulse one cycle after the third handshake; total 6 cycles from the start edge to the last handshake.
- first=0, last=31, x0 read data forced to 32'hDEAD_BEEF, FORCE_X0_ZERO=1 → 32 words; the idx 0 word carries 32'h0; dout_last asserts only on idx 31.
- Wrap-around with first=30, last=1 → indices 30, 31, 0, 1; last on idx 1. With first=5, last=4 → exactly 32 words ending at idx 4.
- Backpressure: dout_ready toggled randomly → dout_data/dout_idx/dout_last stay stable while valid&&!ready; no word is lost or duplicated; start pulsed while busy is ignored.
- Same-cycle write: writeback to x7 (32'hAAAA_AAAA→32'h5555_5555) in the READ cycle for idx 7 → word reports 32'hAAAA_AAAA.
- abort during SEND of the 2nd word → dout_valid drops the next cycle, done pulses once, FSM returns to IDLE. Async rst mid-dump → all outputs 0 immediately and no done pulse.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rf_pkg                                                                |
// | Register-file geometry and the dump-reader FSM state type.            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_e;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | regfile_dump_reader                                                   |
// | Walks a wrapping index range over the register file debug read port   |
// | and streams each value out on a valid/ready channel.                  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module regfile_dump_reader #(
  parameter int RF_DEPTH      = 32,
  parameter int DATA_W        = rf_pkg::RF_DATA_W,
  parameter int FORCE_X0_ZERO = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [rf_pkg::RF_ADDR_W-1:0]  first_idx,
  input  logic [rf_pkg::RF_ADDR_W-1:0]  last_idx,
  output logic [rf_pkg::RF_ADDR_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0]             rf_rdata,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [DATA_W-1:0]             dout_data,
  output logic [rf_pkg::RF_ADDR_W-1:0]  dout_idx,
  output logic                          dout_last,
  output logic                          busy,
  output logic                          done
);

  import rf_pkg::*;

  localparam logic [RF_ADDR_W-1:0] c_idx_max = RF_ADDR_W'(RF_DEPTH - 1);

  dump_state_e            r_state;
  dump_state_e            w_state_nxt;
  logic [RF_ADDR_W-1:0]   r_idx;
  logic [RF_ADDR_W-1:0]   r_end;
  logic [RF_ADDR_W-1:0]   w_idx_inc;
  logic                   r_dout_valid;
  logic [DATA_W-1:0]      r_dout_data;
  logic [RF_ADDR_W-1:0]   r_dout_idx;
  logic                   r_dout_last;
  logic                   r_done;
  logic                   w_hs;
  logic                   w_abort_act;
  logic                   w_zero_x0;

  assign w_hs        = r_dout_valid & dout_ready;
  assign w_abort_act = abort & ((r_state == READ) | (r_state == SEND));
  assign w_idx_inc   = (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
  assign w_zero_x0   = (FORCE_X0_ZERO != 0) && (r_idx == '0);

  // Next-state decode; abort only matters while a dump is in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = READ;
        end
      end
      READ: begin
        w_state_nxt = w_abort_act ? DONE : SEND;
      end
      SEND: begin
        if (w_abort_act) begin
          w_state_nxt = DONE;
        end else if (w_hs) begin
          w_state_nxt = r_dout_last ? DONE : READ;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_end        <= '0;
      r_dout_valid <= 1'b0;
      r_dout_data  <= '0;
      r_dout_idx   <= '0;
      r_dout_last  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // done rises on entry to DONE, so it is high for exactly the DONE cycle
      r_done <= (w_state_nxt == DONE) && (r_state != DONE);
      if (w_abort_act) begin
        r_dout_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_idx <= first_idx;
              r_end <= last_idx;
            end
          end
          READ: begin
            r_dout_data  <= w_zero_x0 ? '0 : rf_rdata;
            r_dout_idx   <= r_idx;
            r_dout_last  <= (r_idx == r_end);
            r_dout_valid <= 1'b1;
          end
          SEND: begin
            if (w_hs) begin
              r_dout_valid <= 1'b0;
              if (!r_dout_last) begin
                r_idx <= w_idx_inc;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign rf_raddr   = (r_state == READ) ? r_idx : '0;
  assign busy       = (r_state == READ) || (r_state == SEND);
  assign dout_valid = r_dout_valid;
  assign dout_data  = r_dout_data;
  assign dout_idx   = r_dout_idx;
  assign dout_last  = r_dout_last;
  assign done       = r_done;

endmodule : regfile_dump_reader
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_regfile_dump_reader                                                |
// | Randomized self-checking bench with a queue-based dump model.         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  first_idx = '0;
  logic [4:0]  last_idx = '0;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [31:0] dout_data;
  logic [4:0]  dout_idx;
  logic        dout_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic [37:0] obs_w[$];
  logic [37:0] exp_w[$];
  int s_edge, hs_edge, done_cyc, done_cnt, stab_err, raddr_err;
  logic [4:0] first_raddr;
  logic       first_busy;
  bit         timed_out;

  regfile_dump_reader #(.RF_DEPTH(32), .DATA_W(32), .FORCE_X0_ZERO(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_idx(first_idx), .last_idx(last_idx),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_idx(dout_idx), .dout_last(dout_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rf_rdata = rf[rf_raddr];

  task automatic preload(input bit randomize_it, input logic [31:0] x0_val);
    for (int i = 0; i < 32; i++)
      rf[i] <= randomize_it ? 32'($urandom) : 32'h1000_0000 + 32'(i);
    rf[0] <= x0_val;
    @(negedge clk);
  endtask

  // Reference: word count and contents follow from the index range alone.
  task automatic build_exp(input logic [4:0] f, input logic [4:0] l);
    int n;
    int i;
    exp_w.delete();
    n = (((int'(l) - int'(f)) % 32 + 32) % 32) + 1;
    for (int k = 0; k < n; k++) begin
      i = (int'(f) + k) % 32;
      exp_w.push_back({5'(i), (i == 0) ? 32'h0 : rf[i], k == n - 1});
    end
  endtask

  task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int rdy_pct,
                         input bit poke_start, input bit wb, input logic [31:0] wb_val);
    logic [37:0] held;
    bit have_held;
    bit finished;
    int post;
    obs_w.delete();
    hs_edge = -1; done_cyc = -1; done_cnt = 0; stab_err = 0; raddr_err = 0;
    have_held = 0; finished = 0; post = 0; held = '0;
    @(negedge clk);
    first_idx = f; last_idx = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_edge = cyc; first_raddr = rf_raddr; first_busy = busy;
    for (int k = 0; k < 400; k++) begin
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (dout_valid && rf_raddr != 5'd0) raddr_err++;
      if (have_held && {dout_valid, dout_idx, dout_data, dout_last} !== {1'b1, held}) stab_err++;
      if (done_cyc >= 0) post++;
      if (post > 3) begin
        finished = 1;
        break;
      end
      dout_ready = ($urandom_range(99) < 32'(rdy_pct));
      if (poke_start && busy && k == 3) begin
        start = 1'b1; first_idx = ~f; last_idx = f;
      end else begin
        start = 1'b0;
      end
      if (dout_valid && dout_ready) begin
        obs_w.push_back({dout_idx, dout_data, dout_last});
        hs_edge = cyc + 1;
        have_held = 0;
      end else if (dout_valid) begin
        have_held = 1;
        held = {dout_idx, dout_data, dout_last};
      end else begin
        have_held = 0;
      end
      if (wb && k == 0) begin
        @(posedge clk);
        rf[f] <= wb_val;
      end
      @(negedge clk);
    end
    timed_out = !finished;
    dout_ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({rf_raddr, dout_valid, dout_data, dout_idx, dout_last, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=0", {rf_raddr, dout_valid, dout_data, dout_idx, dout_last, busy, done});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rf_raddr, dout_valid, dout_data, dout_idx, dout_last, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_release got=%h exp=0", {rf_raddr, dout_valid, dout_data, dout_idx, dout_last, busy, done});
    end
  endtask

  task automatic test_basic();
    preload(0, 32'h0);
    build_exp(5'd1, 5'd3);
    do_dump(5'd1, 5'd3, 100, 0, 0, 32'h0);
    checks++;
    if (timed_out) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
    checks++;
    if (obs_w.size() != exp_w.size()) begin
      failures++; $display("FAIL basic_count got=%0d exp=%0d", obs_w.size(), exp_w.size());
    end
    for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
      checks++;
      if (obs_w[k] !== exp_w[k]) begin
        failures++; $display("FAIL basic_word%0d got=%h exp=%h", k, obs_w[k], exp_w[k]);
      end
    end
    checks++;
    if (first_raddr !== 5'd1 || first_busy !== 1'b1) begin
      failures++; $display("FAIL basic_read_port got=%0d/%0b exp=1/1", first_raddr, first_busy);
    end
    checks++;
    if (hs_edge - s_edge != 6) begin
      failures++; $display("FAIL basic_latency got=%0d exp=6", hs_edge - s_edge);
    end
    checks++;
    if (done_cyc != hs_edge || done_cnt != 1) begin
      failures++; $display("FAIL basic_done got=cyc%0d/cnt%0d exp=cyc%0d/cnt1", done_cyc, done_cnt, hs_edge);
    end
    checks++;
    if (raddr_err != 0) begin failures++; $display("FAIL basic_raddr_idle got=%0d exp=0", raddr_err); end
  endtask

  task automatic test_full();
    preload(1, 32'hDEAD_BEEF);
    build_exp(5'd0, 5'd31);
    do_dump(5'd0, 5'd31, 100, 0, 0, 32'h0);
    checks++;
    if (obs_w.size() != 32 || timed_out) begin
      failures++; $display("FAIL full_count got=%0d exp=32", obs_w.size());
    end
    for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
      checks++;
      if (obs_w[k] !== exp_w[k]) begin
        failures++; $display("FAIL full_word%0d got=%h exp=%h", k, obs_w[k], exp_w[k]);
      end
    end
    checks++;
    if (obs_w.size() > 0 && obs_w[0][32:1] !== 32'h0) begin
      failures++; $display("FAIL full_x0_zero got=%h exp=0", obs_w[0][32:1]);
    end
    checks++;
    if (hs_edge - s_edge != 64) begin
      failures++; $display("FAIL full_latency got=%0d exp=64", hs_edge - s_edge);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] fs [2];
    logic [4:0] ls [2];
    fs[0] = 5'd30; ls[0] = 5'd1; fs[1] = 5'd5; ls[1] = 5'd4;
    for (int t = 0; t < 2; t++) begin
      preload(1, 32'h1234_5678);
      build_exp(fs[t], ls[t]);
      do_dump(fs[t], ls[t], 70, 0, 0, 32'h0);
      checks++;
      if (obs_w.size() != exp_w.size() || timed_out) begin
        failures++; $display("FAIL wrap%0d_count got=%0d exp=%0d", t, obs_w.size(), exp_w.size());
      end
      for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
        checks++;
        if (obs_w[k] !== exp_w[k]) begin
          failures++; $display("FAIL wrap%0d_word%0d got=%h exp=%h", t, k, obs_w[k], exp_w[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] f;
    logic [4:0] l;
    for (int t = 0; t < 4; t++) begin
      f = 5'($urandom); l = 5'($urandom);
      preload(1, 32'($urandom));
      build_exp(f, l);
      do_dump(f, l, 40, 1, 0, 32'h0);
      checks++;
      if (obs_w.size() != exp_w.size() || timed_out || done_cnt != 1) begin
        failures++;
        $display("FAIL bp%0d_count got=%0d/done%0d exp=%0d/done1", t, obs_w.size(), done_cnt, exp_w.size());
      end
      for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
        checks++;
        if (obs_w[k] !== exp_w[k]) begin
          failures++; $display("FAIL bp%0d_word%0d got=%h exp=%h", t, k, obs_w[k], exp_w[k]);
        end
      end
      checks++;
      if (stab_err != 0) begin failures++; $display("FAIL bp%0d_stable got=%0d exp=0", t, stab_err); end
    end
  endtask

  task automatic test_same_cycle_write();
    preload(0, 32'h0);
    rf[7] <= 32'hAAAA_AAAA;
    @(negedge clk);
    do_dump(5'd7, 5'd7, 100, 0, 1, 32'h5555_5555);
    checks++;
    if (obs_w.size() != 1 || obs_w[0] !== {5'd7, 32'hAAAA_AAAA, 1'b1}) begin
      failures++;
      $display("FAIL wb_no_bypass got=%h exp=%h", obs_w.size() > 0 ? obs_w[0] : 38'h0, {5'd7, 32'hAAAA_AAAA, 1'b1});
    end
  endtask

  task automatic test_abort();
    int extra_done;
    preload(0, 32'h0);
    @(negedge clk);
    first_idx = 5'd10; last_idx = 5'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b1 || dout_idx !== 5'd11) begin
      failures++; $display("FAIL abort_pre got=%b/%0d exp=1/11", dout_valid, dout_idx);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({dout_valid, done, busy} !== 3'b010) begin
      failures++; $display("FAIL abort_resp got=%b exp=010", {dout_valid, done, busy});
    end
    extra_done = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || dout_valid || busy) extra_done++;
    end
    checks++;
    if (extra_done != 0) begin failures++; $display("FAIL abort_idle got=%0d exp=0", extra_done); end
    preload(0, 32'h0);
    build_exp(5'd2, 5'd2);
    do_dump(5'd2, 5'd2, 100, 0, 0, 32'h0);
    checks++;
    if (obs_w.size() != 1 || obs_w[0] !== exp_w[0]) begin
      failures++; $display("FAIL abort_restart got=%0d words exp=1", obs_w.size());
    end
  endtask

  task automatic test_async_reset();
    int bad;
    @(negedge clk);
    first_idx = 5'd0; last_idx = 5'd31; start = 1'b1; dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rf_raddr, dout_valid, dout_data, dout_idx, dout_last, busy, done} !== '0) begin
      failures++;
      $display("FAIL async_rst got=%h exp=0", {rf_raddr, dout_valid, dout_data, dout_idx, dout_last, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || dout_valid || busy) bad++;
    end
    dout_ready = 1'b0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL async_rst_nodone got=%0d exp=0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_backpressure();
    test_same_cycle_write();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_regfile_dump_reader
`default_nettype wire
